booth_mul_arbiter: RTL

Round-robin arbiter that shares one `booth_multiplier` instance between `NUM_REQ` requesters.
- Accepts one operand pair at a time from the winning requester.
- Sequences the multiplier's start/ready handshake and captures the product.
- Returns the product on a single tagged response channel with valid/ready flow control.
- Sits between the compute clients and the multiplier, which is instantiated outside this block and connected through the `mul_*` ports.

---
 rtl/booth_mul_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one external booth multiplier across NUM_REQ clients.
// Optional watchdog is compiled in when BOOTH_ARB_TIMEOUT_EN is defined.

module booth_mul_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_m,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_q,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_result,
    output logic                          rsp_err,
    output logic                          mul_start,
    output logic [DATA_WIDTH-1:0]         mul_m,
    output logic [DATA_WIDTH-1:0]         mul_q,
    input  logic [2*DATA_WIDTH-1:0]       mul_result,
    input  logic                          mul_ready
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         rr_q, rr_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ID_W-1:0]         gnt_id;
    logic                    gnt_vld;
    logic                    accept;
    logic                    done;
    logic                    tmo_fire;
    logic [DATA_WIDTH-1:0]   m_q, m_d;
    logic [DATA_WIDTH-1:0]   q_q, q_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 4) begin : g_cfg_check
        $error("booth_mul_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 4");
    end

    // Walk offsets high-to-low so the smallest offset from rr_q wins.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    assign accept = (state_q == S_IDLE) && gnt_vld && rst_n;
    assign done   = (state_q == S_WAIT_DONE) && mul_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // A ready still high in WAIT_BUSY is the previous done, not ours.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (tmo_fire)        state_d = S_RESP;
                else if (!mul_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (mul_ready)     state_d = S_RESP;
                else if (tmo_fire) state_d = S_RESP;
            end
            S_RESP:      if (rsp_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_id] = 1'b1;
        mul_start = (state_q == S_ISSUE);
        rsp_valid = (state_q == S_RESP);
    end

    always_comb begin
        m_d   = m_q;
        q_d   = q_q;
        id_d  = id_q;
        rr_d  = rr_q;
        res_d = res_q;
        if (accept) begin
            m_d  = req_m[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            q_d  = req_q[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            id_d = gnt_id;
            rr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        if (done)     res_d = mul_result;
        if (tmo_fire) res_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            q_q   <= '0;
            id_q  <= '0;
            rr_q  <= '0;
            res_q <= '0;
        end else begin
            m_q   <= m_d;
            q_q   <= q_d;
            id_q  <= id_d;
            rr_q  <= rr_d;
            res_q <= res_d;
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Fires on the TIMEOUT_CYCLES-th cycle spent waiting; a same-cycle done wins.
    assign tmo_fire = ((state_q == S_WAIT_BUSY) || ((state_q == S_WAIT_DONE) && !mul_ready))
                      && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_ISSUE)
            cnt_d = '0;
        else if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE)
            cnt_d = cnt_q + 1'b1;
        if (done)     err_d = 1'b0;
        if (tmo_fire) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign tmo_fire = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign mul_m      = m_q;
    assign mul_q      = q_q;

endmodule
